pio_output_arbiter: RTL and testbench

PIO_OUTPUT_ARBITER -- requirements
Module: pio_output_arbiter

---
 rtl/pio_output_arbiter.sv | 118 +++++++++++
 tb/tb_pio_output_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pio_output_arbiter.sv
// Round-robin arbiter granting three requesters write access to the hex, LEDR and LEDG output registers.
// Each target enforces a minimum idle gap after a write; invalid-target writes are dropped and flagged.
module pio_output_arbiter #(
    parameter int                DATA_W    = 32,
    parameter int                MIN_GAP   = 4,
    parameter logic [DATA_W-1:0] HEX_RESET = 32'hFFFF_FFFF
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [2:0]            req_valid,
    input  logic [5:0]            req_target,
    input  logic [3*DATA_W-1:0]   req_data,
    output logic [2:0]            req_ready,
    input  logic                  err_clr,
    output logic [DATA_W-1:0]     hex_display_out,
    output logic [DATA_W-1:0]     ledr_out,
    output logic [DATA_W-1:0]     ledg_out,
    output logic [1:0]            grant_id,
    output logic                  err_sticky,
    output logic [2:0]            target_busy
);

    localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

    logic [DATA_W-1:0] hex_q, hex_d, ledr_q, ledr_d, ledg_q, ledg_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic              err_q, err_d;
    logic [GAP_W-1:0]  gap_q [3];
    logic [GAP_W-1:0]  gap_d [3];

    logic [1:0]        tgt [3];
    logic [2:0]        elig;
    logic [3:0]        busy4;
    logic [2:0]        cand;
    logic              win_ok;
    logic              xfer;
    logic [1:0]        win_idx;
    logic [1:0]        win_tgt;
    logic [DATA_W-1:0] win_data;

    // Target code 3 always counts as idle so a bad request is never stalled.
    always_comb begin
        busy4 = {1'b0, gap_q[2] != '0, gap_q[1] != '0, gap_q[0] != '0};
        for (int i = 0; i < 3; i++) begin
            tgt[i]  = req_target[2*i +: 2];
            elig[i] = req_valid[i] && ((tgt[i] == 2'd3) || !busy4[tgt[i]]);
        end
        win_ok  = 1'b0;
        win_idx = 2'd0;
        cand    = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!win_ok && elig[cand[1:0]]) begin
                win_ok  = 1'b1;
                win_idx = cand[1:0];
            end
        end
        xfer      = win_ok && reset_reset_n;
        req_ready = 3'b000;
        if (xfer) req_ready[win_idx] = 1'b1;
        win_tgt  = tgt[win_idx];
        win_data = req_data[DATA_W*win_idx +: DATA_W];
    end

    always_comb begin
        hex_d    = hex_q;
        ledr_d   = ledr_q;
        ledg_d   = ledg_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = 2'd3;
        err_d    = err_q;
        for (int t = 0; t < 3; t++) begin
            gap_d[t] = (gap_q[t] != '0) ? gap_q[t] - 1'b1 : '0;
        end
        if (err_clr) err_d = 1'b0;
        if (xfer) begin
            grant_d  = win_idx;
            rr_ptr_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
            case (win_tgt)
                2'd0: begin hex_d  = win_data; gap_d[0] = GAP_LOAD; end
                2'd1: begin ledr_d = win_data; gap_d[1] = GAP_LOAD; end
                2'd2: begin ledg_d = win_data; gap_d[2] = GAP_LOAD; end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            hex_q    <= HEX_RESET;
            ledr_q   <= '0;
            ledg_q   <= '0;
            rr_ptr_q <= 2'd0;
            grant_q  <= 2'd3;
            err_q    <= 1'b0;
            for (int t = 0; t < 3; t++) gap_q[t] <= '0;
        end else begin
            hex_q    <= hex_d;
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            err_q    <= err_d;
            for (int t = 0; t < 3; t++) gap_q[t] <= gap_d[t];
        end
    end

    assign hex_display_out = hex_q;
    assign ledr_out        = ledr_q;
    assign ledg_out        = ledg_q;
    assign grant_id        = grant_q;
    assign err_sticky      = err_q;
    assign target_busy     = busy4[2:0];

endmodule

// File: tb/tb_pio_output_arbiter.sv
// Directed bench for pio_output_arbiter: reset, round robin, gap timing, contention, invalid target, reset mid-operation.
module tb_pio_output_arbiter;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      req_valid;
    logic [5:0]      req_target;
    logic [3*DW-1:0] req_data;
    logic [2:0]      req_ready;
    logic            err_clr;
    logic [DW-1:0]   hex_out, ledr_out, ledg_out;
    logic [1:0]      grant_id;
    logic            err_sticky;
    logic [2:0]      target_busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pio_output_arbiter #(.DATA_W(DW), .MIN_GAP(4), .HEX_RESET(32'hFFFF_FFFF)) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .req_valid       (req_valid),
        .req_target      (req_target),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .err_clr         (err_clr),
        .hex_display_out (hex_out),
        .ledr_out        (ledr_out),
        .ledg_out        (ledg_out),
        .grant_id        (grant_id),
        .err_sticky      (err_sticky),
        .target_busy     (target_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] t, input logic [31:0] d);
        req_valid[i]       = v;
        req_target[2*i +: 2] = t;
        req_data[DW*i +: DW] = d;
    endtask

    initial begin
        int w;
        rst_n      = 1'b0;
        err_clr    = 1'b0;
        req_valid  = '0;
        req_target = '0;
        req_data   = '0;

        // Reset held two cycles with every requester valid
        set_req(0, 1'b1, 2'd0, 32'hAAAA_0001);
        set_req(1, 1'b1, 2'd1, 32'hBBBB_0002);
        set_req(2, 1'b1, 2'd2, 32'hCCCC_0003);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        step();
        step();
        chk("rst_ready2", 32'(req_ready), 32'h0);
        chk("rst_hex", hex_out, 32'hFFFF_FFFF);
        chk("rst_ledr", ledr_out, 32'h0);
        chk("rst_ledg", ledg_out, 32'h0);
        chk("rst_grant", 32'(grant_id), 32'd3);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_busy", 32'(target_busy), 32'd0);

        // Round robin across three targets
        rst_n = 1'b1;
        #1;
        chk("rr_ready0", 32'(req_ready), 32'b001);
        step();
        chk("rr_hex", hex_out, 32'hAAAA_0001);
        chk("rr_grant0", 32'(grant_id), 32'd0);
        set_req(0, 1'b0, 2'd0, 32'h0);
        #1;
        chk("rr_ready1", 32'(req_ready), 32'b010);
        step();
        chk("rr_ledr", ledr_out, 32'hBBBB_0002);
        chk("rr_grant1", 32'(grant_id), 32'd1);
        set_req(1, 1'b0, 2'd0, 32'h0);
        #1;
        chk("rr_ready2", 32'(req_ready), 32'b100);
        step();
        chk("rr_ledg", ledg_out, 32'hCCCC_0003);
        chk("rr_grant2", 32'(grant_id), 32'd2);
        set_req(2, 1'b0, 2'd0, 32'h0);
        #1;
        chk("rr_idle_ready", 32'(req_ready), 32'h0);
        step();
        chk("rr_idle_grant", 32'(grant_id), 32'd3);

        // Back-to-back writes to hex by requester 0
        repeat (5) step();
        set_req(0, 1'b1, 2'd0, 32'h0000_0001);
        #1;
        chk("gap_ready_first", 32'(req_ready), 32'b001);
        step();
        chk("gap_hex1", hex_out, 32'h1);
        set_req(0, 1'b1, 2'd0, 32'h0000_0002);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("gap_ready_held", 32'(req_ready), 32'h0);
            chk("gap_busy", 32'(target_busy[0]), 32'd1);
            chk("gap_hex_hold", hex_out, 32'h1);
            step();
        end
        #1;
        chk("gap_ready_second", 32'(req_ready), 32'b001);
        chk("gap_busy_clear", 32'(target_busy[0]), 32'd0);
        step();
        chk("gap_hex2", hex_out, 32'h2);
        chk("gap_grant", 32'(grant_id), 32'd0);
        set_req(0, 1'b0, 2'd0, 32'h0);

        // Requesters 1 and 2 contend for ledr, pointer at 1
        set_req(1, 1'b1, 2'd1, 32'h1111_D001);
        set_req(2, 1'b1, 2'd1, 32'h2222_D002);
        #1;
        chk("cont_ready1", 32'(req_ready), 32'b010);
        step();
        chk("cont_ledr1", ledr_out, 32'h1111_D001);
        chk("cont_grant1", 32'(grant_id), 32'd1);
        set_req(1, 1'b0, 2'd0, 32'h0);
        w = 0;
        #1;
        while (req_ready !== 3'b100 && w < 20) begin
            step();
            #1;
            w++;
        end
        chk("cont_wait", 32'(w), 32'd4);
        step();
        chk("cont_ledr2", ledr_out, 32'h2222_D002);
        chk("cont_grant2", 32'(grant_id), 32'd2);
        set_req(2, 1'b0, 2'd0, 32'h0);

        // Invalid target with err_clr in the same cycle
        set_req(2, 1'b1, 2'd3, 32'hDEAD_BEEF);
        err_clr = 1'b1;
        #1;
        chk("inv_ready", 32'(req_ready), 32'b100);
        step();
        chk("inv_err_set", 32'(err_sticky), 32'd1);
        chk("inv_grant", 32'(grant_id), 32'd2);
        chk("inv_hex", hex_out, 32'h2);
        chk("inv_ledr", ledr_out, 32'h2222_D002);
        chk("inv_ledg", ledg_out, 32'hCCCC_0003);
        chk("inv_busy", 32'(target_busy), 32'b010);
        set_req(2, 1'b0, 2'd0, 32'h0);
        step();
        chk("inv_err_clr", 32'(err_sticky), 32'd0);
        err_clr = 1'b0;

        // Move pointer to 2, then reset with requests pending
        set_req(1, 1'b1, 2'd2, 32'h6666_0006);
        #1;
        chk("mid_ready_pre", 32'(req_ready), 32'b010);
        step();
        chk("mid_ledg_pre", ledg_out, 32'h6666_0006);
        set_req(1, 1'b0, 2'd0, 32'h0);
        set_req(0, 1'b1, 2'd0, 32'hEEEE_000E);
        set_req(2, 1'b1, 2'd2, 32'hFFFF_000F);
        rst_n = 1'b0;
        #1;
        chk("mid_ready_rst", 32'(req_ready), 32'h0);
        step();
        chk("mid_hex", hex_out, 32'hFFFF_FFFF);
        chk("mid_ledr", ledr_out, 32'h0);
        chk("mid_ledg", ledg_out, 32'h0);
        chk("mid_grant", 32'(grant_id), 32'd3);
        chk("mid_busy", 32'(target_busy), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_ready_rel", 32'(req_ready), 32'b001);
        step();
        chk("mid_hex_after", hex_out, 32'hEEEE_000E);
        chk("mid_grant_after", 32'(grant_id), 32'd0);
        set_req(0, 1'b0, 2'd0, 32'h0);
        #1;
        chk("mid_ready_next", 32'(req_ready), 32'b100);
        step();
        chk("mid_ledg_after", ledg_out, 32'hFFFF_000F);
        chk("mid_grant_next", 32'(grant_id), 32'd2);
        set_req(2, 1'b0, 2'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
